// File: rtl/vpu_operand_dispatcher.sv
// Lockstep operand dispatcher: pops all enabled source queues together and
// registers the aligned operand set into a valid/ready stage toward the VLANEs.
module vpu_operand_dispatcher #(
   parameter int unsigned SRC_CNT     = 3,
   parameter int unsigned LANE_DATA_W = 256,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_i,
   input  logic [SRC_CNT-1:0]     src_mask_i,
   input  logic [CNT_W-1:0]       len_i,
   input  logic                   reset_cmd_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [SRC_CNT-1:0]     rden_o,
   input  logic [LANE_DATA_W-1:0] rdata_i [SRC_CNT],
   input  logic [SRC_CNT-1:0]     rdempty_i,
   output logic                   op_valid_o,
   input  logic                   op_ready_i,
   output logic [LANE_DATA_W-1:0] op_data_o [SRC_CNT],
   output logic                   op_last_o
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [SRC_CNT-1:0] mask_q;
   logic [CNT_W-1:0]   rem_q;
   logic               srcs_ready;
   logic               fire;
   logic               last_hs;
   logic               start_ok;
   logic               zero_start;
   logic               done_d;

   always_comb begin
      srcs_ready = &(~rdempty_i | ~mask_q);
      fire       = (state_q == RUN) && (rem_q != '0) && srcs_ready &&
                   (!op_valid_o || op_ready_i) && !reset_cmd_i;
      // Empty gating is redundant with srcs_ready but keeps the no-pop-on-empty rule local.
      rden_o     = fire ? (mask_q & ~rdempty_i) : '0;
      last_hs    = op_valid_o && op_ready_i && op_last_o;
      start_ok   = (state_q == IDLE) && start_i && !reset_cmd_i;
      zero_start = start_ok && ((len_i == '0) || (src_mask_i == '0));
      busy_o     = (state_q != IDLE);
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      if (reset_cmd_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               done_d = zero_start;
               if (start_ok && !zero_start) state_d = RUN;
            end
            RUN: begin
               if (fire && (rem_q == CNT_W'(1))) state_d = DRAIN;
            end
            DRAIN: begin
               if (last_hs) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         done_o  <= 1'b0;
         mask_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         done_o  <= done_d;
         if (reset_cmd_i) begin
            rem_q <= '0;
         end else if (start_ok && !zero_start) begin
            mask_q <= src_mask_i;
            rem_q  <= len_i;
         end else if (fire) begin
            rem_q <= rem_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_valid_o <= 1'b0;
         op_last_o  <= 1'b0;
         for (int unsigned j = 0; j < SRC_CNT; j++) op_data_o[j] <= '0;
      end else if (reset_cmd_i) begin
         op_valid_o <= 1'b0;
         op_last_o  <= 1'b0;
      end else if (fire) begin
         op_valid_o <= 1'b1;
         op_last_o  <= (rem_q == CNT_W'(1));
         for (int unsigned j = 0; j < SRC_CNT; j++)
            op_data_o[j] <= mask_q[j] ? rdata_i[j] : '0;
      end else if (op_ready_i) begin
         op_valid_o <= 1'b0;
         op_last_o  <= 1'b0;
      end
   end

endmodule
